// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: runtime-programmable clock divider with one-cycle tick.
// A new ratio is applied only at a period boundary, so clk_out never produces a runt pulse.
// Optional feature: define CLK_DIV_CTRL_PERIOD_CNT_EN to add the period_cnt[15:0] output.
module clk_div_ctrl #(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned DEF_DIV = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             clk_out,
   output logic             tick,
   output logic             active
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
   ,
   output logic [15:0]      period_cnt
`endif
);

   typedef enum logic [1:0] {StIdle, StRun, StPend} state_e;

   localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEF_DIV);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cur_div_q, cur_div_d;
   logic [CNT_W-1:0] pend_div_q, pend_div_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic             cfg_err_q, cfg_err_d;
   logic             hs, legal, wrap;

   assign cfg_ready = (state_q != StPend);
   assign active    = (state_q != StIdle);
   assign clk_out   = clk_out_q;
   assign tick      = tick_q;
   assign cfg_err   = cfg_err_q;

   // Next-state: counter, ratio bookkeeping and registered output shaping.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cur_div_d  = cur_div_q;
      pend_div_d = pend_div_q;
      hs         = cfg_valid && cfg_ready;
      legal      = (cfg_div >= CNT_W'(2));
      wrap       = (cnt_q == (cur_div_q - CNT_W'(1)));
      cfg_err_d  = hs && !legal;

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (hs && legal) cur_div_d = cfg_div;
            if (en) state_d = StRun;
         end
         StRun: begin
            if (wrap) begin
               // A ratio arriving exactly on the wrap edge governs the next period directly.
               if (hs && legal) cur_div_d = cfg_div;
               cnt_d = '0;
               if (!en) state_d = StIdle;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (hs && legal) begin
                  pend_div_d = cfg_div;
                  state_d    = StPend;
               end
            end
         end
         StPend: begin
            if (wrap) begin
               cur_div_d = pend_div_q;
               cnt_d     = '0;
               state_d   = en ? StRun : StIdle;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase

      // Outputs describe the cycle that cnt_d will represent, using the ratio in force then.
      clk_out_d = (state_d != StIdle) && (cnt_d < (cur_div_d >> 1));
      tick_d    = (state_d != StIdle) && (cnt_d == '0);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         cur_div_q  <= DefDiv;
         pend_div_q <= DefDiv;
         clk_out_q  <= 1'b0;
         tick_q     <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cur_div_q  <= cur_div_d;
         pend_div_q <= pend_div_d;
         clk_out_q  <= clk_out_d;
         tick_q     <= tick_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
   logic [15:0] period_cnt_q;

   assign period_cnt = period_cnt_q;

   // Period counter: cleared on each start from idle, then bumped once per tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_cnt_q <= '0;
      end else if (state_q == StIdle && state_d == StRun) begin
         period_cnt_q <= '0;
      end else if (tick_q) begin
         period_cnt_q <= period_cnt_q + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: expected output vectors are queued as stimulus is driven and
// compared one cycle later. Vector order: {clk_out, tick, active, cfg_ready, cfg_err}.
module tb_clk_div_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       cfg_valid;
   logic [7:0] cfg_div;
   logic       cfg_ready, cfg_err, clk_out, tick, active;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
   logic [15:0] period_cnt;
`endif

   int         n_tests = 0;
   int         n_fails = 0;
   logic [4:0] exp_q[$];
   logic [4:0] obs;

   assign obs = {clk_out, tick, active, cfg_ready, cfg_err};

   always #5 clk = ~clk;

   clk_div_ctrl #(.CNT_W(8), .DEF_DIV(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .clk_out   (clk_out),
      .tick      (tick),
      .active    (active)
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
      ,
      .period_cnt(period_cnt)
`endif
   );

   task automatic test_reset();
      logic [4:0] e;
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back(5'b00010);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin
         $display("FAIL reset got %b want %b", obs, e);
         n_fails++;
      end
      rst_n = 1'b1;
      exp_q.push_back(5'b00010);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin
         $display("FAIL idle got %b want %b", obs, e);
         n_fails++;
      end
   endtask

   // N=4 from idle: 1,1,0,0 with a tick on each cnt==0, first tick right after en.
   task automatic test_basic();
      logic [4:0] e;
      en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         exp_q.push_back({((i % 4) < 2) ? 1'b1 : 1'b0, ((i % 4) == 0) ? 1'b1 : 1'b0, 3'b110});
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_tests++;
         if (obs !== e) begin
            $display("FAIL basic[%0d] got %b want %b", i, obs, e);
            n_fails++;
         end
      end
   endtask

   // Ratio 5 offered at cnt=1: current period stays 4, then 5-cycle periods.
   task automatic test_pend();
      logic [4:0] e;
      logic [4:0] tab [14] = '{5'b11110, 5'b10110, 5'b00100, 5'b00100, 5'b11110, 5'b10110,
                               5'b00110, 5'b00110, 5'b00110, 5'b11110, 5'b10110, 5'b00110,
                               5'b00110, 5'b00110};
      for (int i = 0; i < 14; i++) begin
         cfg_valid = (i == 2);
         cfg_div   = 8'd5;
         exp_q.push_back(tab[i]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_tests++;
         if (obs !== e) begin
            $display("FAIL pend[%0d] got %b want %b", i, obs, e);
            n_fails++;
         end
      end
      cfg_valid = 1'b0;
   endtask

   // Ratio 3 offered on the wrap edge: applied immediately, ready never drops.
   task automatic test_wrap_apply();
      logic [4:0] e;
      logic [4:0] tab [7] = '{5'b11110, 5'b00110, 5'b00110, 5'b11110, 5'b00110, 5'b00110,
                              5'b11110};
      for (int i = 0; i < 7; i++) begin
         cfg_valid = (i == 0);
         cfg_div   = 8'd3;
         exp_q.push_back(tab[i]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_tests++;
         if (obs !== e) begin
            $display("FAIL wrap_apply[%0d] got %b want %b", i, obs, e);
            n_fails++;
         end
      end
      cfg_valid = 1'b0;
   endtask

   // Ratios 1 and 0 are dropped with an error pulse; spacing stays at 3.
   task automatic test_illegal();
      logic [4:0] e;
      logic [4:0] tab [9] = '{5'b00111, 5'b00110, 5'b11111, 5'b00110, 5'b00110, 5'b11110,
                              5'b00110, 5'b00110, 5'b11110};
      for (int i = 0; i < 9; i++) begin
         cfg_valid = (i == 0) || (i == 2);
         cfg_div   = (i == 0) ? 8'd1 : 8'd0;
         exp_q.push_back(tab[i]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_tests++;
         if (obs !== e) begin
            $display("FAIL illegal[%0d] got %b want %b", i, obs, e);
            n_fails++;
         end
      end
      cfg_valid = 1'b0;
   endtask

   // Load N=6, drop en at cnt=2: period completes, go idle, restart one cycle after en.
   task automatic test_stop();
      logic [4:0] e;
      logic [4:0] tab [13] = '{5'b00100, 5'b00100, 5'b11110, 5'b10110, 5'b10110, 5'b00110,
                               5'b00110, 5'b00110, 5'b00010, 5'b00010, 5'b00010, 5'b11110,
                               5'b10110};
      for (int i = 0; i < 13; i++) begin
         cfg_valid = (i == 0);
         cfg_div   = 8'd6;
         en        = !(i >= 5 && i <= 10);
         exp_q.push_back(tab[i]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_tests++;
         if (obs !== e) begin
            $display("FAIL stop[%0d] got %b want %b", i, obs, e);
            n_fails++;
         end
      end
      cfg_valid = 1'b0;
   endtask

   // Async reset in the high phase clears outputs at once; restart runs at DEF_DIV.
   task automatic test_async_reset();
      logic [4:0] e;
      logic [4:0] tab [5] = '{5'b11110, 5'b10110, 5'b00110, 5'b00110, 5'b11110};
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.push_back(5'b00010);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin
         $display("FAIL async_reset got %b want %b", obs, e);
         n_fails++;
      end
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(tab[i]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_tests++;
         if (obs !== e) begin
            $display("FAIL restart[%0d] got %b want %b", i, obs, e);
            n_fails++;
         end
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
         if (i < 2) begin
            n_tests++;
            if (period_cnt !== 16'(i)) begin
               $display("FAIL period_cnt[%0d] got %0d want %0d", i, period_cnt, i);
               n_fails++;
            end
         end
`endif
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      en        = 1'b0;
      cfg_valid = 1'b0;
      cfg_div   = 8'd0;
      test_reset();
      test_basic();
      test_pend();
      test_wrap_apply();
      test_illegal();
      test_stop();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
      $finish;
   end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Runtime-programmable clock-divider controller. It generates a divided clock and a one-cycle tick from the system clock.
- The divide ratio is loaded through a valid/ready config handshake. A new ratio takes effect only at a period boundary, so the output never produces a runt pulse.
- Start and stop are controlled by a level enable. Stopping waits for the current period to complete.
- Sits between the control/register logic and any logic that needs a slowed clock or clock-enable.

Parameters:
- CNT_W, 8, width of divide ratio and internal counter.
- DEF_DIV, 4, ratio loaded at reset; must be >= 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run request, level-sensitive.
- cfg_valid  input  1  new ratio offered.
- cfg_div  input  CNT_W  requested divide ratio N.
- cfg_ready  output  1  controller can accept a ratio this cycle.
- cfg_err  output  1  one-cycle pulse: offered ratio was illegal and was dropped.
- clk_out  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse in the first cycle of each period, registered.
- active  output  1  high while a period is in progress.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, cur_div=DEF_DIV, pend_div=DEF_DIV.
  - clk_out=0, tick=0, cfg_err=0. cfg_ready=1, active=0.
- Period shape for ratio N, with H = N>>1:
  - cnt runs 0..N-1 and wraps to 0.
  - clk_out is 1 while cnt is 0..H-1 and 0 while cnt is H..N-1.
  - Result: H high cycles, N-H low cycles. Even N gives 50% duty; odd N has the extra cycle low.
  - tick=1 exactly in the cycle where cnt==0 while running.
- States: IDLE, RUN, PEND.
  - cfg_ready = (state != PEND), combinational from state.
  - active = (state != IDLE).
- IDLE:
  - cnt=0, clk_out=0, tick=0.
  - Accepted legal config updates cur_div immediately.
  - en=1 at an edge: next cycle state=RUN, cnt=0, clk_out=1, tick=1. Start latency is 1 clock.
  - If a legal config is accepted on the same edge as start, the new ratio governs the first period.
- RUN:
  - A legal cfg_valid&cfg_ready stores pend_div and moves to PEND.
  - Exception: if the handshake lands on the wrap edge (cnt==cur_div-1), the ratio is applied directly to the next period and the state stays RUN.
- PEND:
  - cfg_ready=0; further cfg_valid is held off, not dropped.
  - On the wrap edge: cur_div<=pend_div, state=RUN (or IDLE if en=0).
- Wrap edge (cnt==cur_div-1) in RUN/PEND:
  - en=1: cnt<=0, clk_out<=1, tick<=1, using the newly applied ratio.
  - en=0: state<=IDLE, cnt<=0, clk_out stays 0, tick=0. Any pending ratio is applied before going idle.
- en deasserted mid-period: the period completes; there is no truncation. Re-asserting en before the wrap cancels the stop.
- Illegal ratio: cfg_div < 2 on a handshake is accepted (ready was high) but dropped.
  - cfg_err pulses for 1 cycle.
  - cur_div, pend_div and state are unchanged.
- Reset mid-period: all outputs return immediately to their reset values. Nothing pending survives.
- Arithmetic:
  - cnt is CNT_W bits. Compares use cur_div-1, so the maximum N is 2^CNT_W-1.
  - No divider; H is a bit-shift.

Optional Feature:
- Macro CLK_DIV_CTRL_PERIOD_CNT_EN.
- Defined: adds output period_cnt[15:0].
  - Increments by 1 on every tick and wraps 0xFFFF->0.
  - Clears to 0 on reset, and on any IDLE->RUN transition.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, en=1 with DEF_DIV=4 -> clk_out pattern 1,1,0,0 repeating; tick every 4th cycle; first tick 1 cycle after en seen; active=1.
- Running N=4, offer cfg_div=5 with cnt=1 -> cfg_ready drops to 0, current period stays 4 cycles; next period is 1,1,0,0,0 and tick spacing becomes 5.
- Offer cfg_div=3 exactly on the wrap edge -> state stays RUN, cfg_ready stays 1, next period is 1,0,0.
- Offer cfg_div=1 then cfg_div=0 -> cfg_err pulses once per offer, ratio unchanged, tick spacing unchanged.
- Running N=6, drop en at cnt=2 -> the period finishes through cnt=5, then active=0, clk_out=0, no further tick. Re-raise en -> tick 1 cycle later.
- Assert rst_n=0 asynchronously mid-high-phase -> clk_out, tick, active go 0 immediately. After release with en=1, clk_out resumes at DEF_DIV. With CLK_DIV_CTRL_PERIOD_CNT_EN defined, period_cnt restarts from 0.
